// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
//   Shared definitions for the UART receiver: FSM state encoding, frame
//   data width and the default bit period (50 MHz system clock, 9600 baud).
//   No ports; imported by the interface and by the receiver modules.
package uart_rx_pkg;

  localparam int DATA_BITS              = 8;
  localparam int UART_CLOCK_BIT_DEFAULT = 5208;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if
//   Bundles the serial line and the parallel byte port of the receiver.
//   Signals:
//     rx          serial input, idle high
//     readdata    last correctly received byte
//     valid       one-cycle strobe, readdata updated
//     frame_error one-cycle strobe, stop bit sampled low
//     active      high while a frame is being received
//   Modports:
//     master  line driver / byte consumer side (drives rx)
//     slave   the receiver itself (drives the byte port)
interface uart_rx_if import uart_rx_pkg::*; ();

  logic                 rx;
  logic [DATA_BITS-1:0] readdata;
  logic                 valid;
  logic                 frame_error;
  logic                 active;

  modport master (output rx, input readdata, valid, frame_error, active);
  modport slave  (input rx, output readdata, valid, frame_error, active);

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// uart_rx_sync_2ff
//   Two-flop synchronizer for a single asynchronous input.
//   Ports:
//     clock  system clock, rising edge
//     reset  asynchronous active-low reset; both flops load preset
//     d      asynchronous input
//     q      synchronized output
//   Parameter preset: value held by both flops while in reset.
module uart_rx_sync_2ff #(
  parameter logic preset = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= preset;
      q    <= preset;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx
//   8N1 serial receiver. Recovers frames from the rx line, samples each bit
//   once at its middle, checks start and stop bits and presents the byte on
//   a parallel port with a one-cycle valid strobe.
//   Ports:
//     clock   system clock, rising edge
//     reset   asynchronous active-low reset
//     bus     uart_rx_if.slave: rx in; readdata, valid, frame_error, active out
//   Parameter uart_clock_bit: clock cycles per bit, must be >= 4.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | line idle; wait for rx_s low (or for rx_s high after a bad stop)
//   START | count to mid start bit, confirm the line is still low
//   DATA  | sample one data bit per bit period, LSB first
//   STOP  | sample mid stop bit, strobe valid or frame_error, back to IDLE
module uart_rx import uart_rx_pkg::*; #(
  parameter int uart_clock_bit = UART_CLOCK_BIT_DEFAULT
) (
  input  logic     clock,
  input  logic     reset,
  uart_rx_if.slave bus
);

  localparam int             CW       = $clog2(uart_clock_bit);
  localparam logic [CW-1:0]  CNT_LAST = CW'(uart_clock_bit - 1);
  localparam logic [CW-1:0]  CNT_HALF = CW'(uart_clock_bit / 2 - 1);
  localparam logic [2:0]     IDX_LAST = 3'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] readdata_q, readdata_n;
  logic                 valid_q, valid_n;
  logic                 ferr_q, ferr_n;
  logic                 active_q, active_n;
  // Set by a bad stop bit: a held-low line (break) must go high again
  // before another start bit is accepted.
  logic                 hold_q, hold_n;

  uart_rx_sync_2ff #(.preset(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.rx),
    .q     (rx_s)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      readdata_q <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      active_q   <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      shift      <= shift_n;
      readdata_q <= readdata_n;
      valid_q    <= valid_n;
      ferr_q     <= ferr_n;
      active_q   <= active_n;
      hold_q     <= hold_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    shift_n    = shift;
    readdata_n = readdata_q;
    valid_n    = 1'b0;
    ferr_n     = 1'b0;
    hold_n     = hold_q;

    case (state)
      IDLE: begin
        if (hold_q) begin
          if (rx_s) hold_n = 1'b0;
        end else if (!rx_s) begin
          cnt_n   = '0;
          state_n = START;
        end
      end

      START: begin
        if (cnt == CNT_HALF) begin
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            cnt_n   = '0;
            idx_n   = '0;
            state_n = DATA;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n          = '0;
          shift_n[idx]   = rx_s;
          // idx wraps 7 -> 0 on the last data bit, ready for the next frame.
          idx_n          = idx + 3'd1;
          if (idx == IDX_LAST) state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      STOP: begin
        if (cnt == CNT_LAST) begin
          // Leave at mid stop bit so a back-to-back start edge is not missed.
          cnt_n   = '0;
          state_n = IDLE;
          if (rx_s) begin
            readdata_n = shift;
            valid_n    = 1'b1;
          end else begin
            ferr_n = 1'b1;
            hold_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase

    active_n = (state_n != IDLE);
  end

  assign bus.readdata    = readdata_q;
  assign bus.valid       = valid_q;
  assign bus.frame_error = ferr_q;
  assign bus.active      = active_q;

endmodule
